// File: rtl/mem_bridge_pkg.sv
// mem_bridge_pkg: shared types and constants for the memory bridge.
//   state_e      - bridge FSM states (IDLE / WAIT / RESP)
//   DEF_TIMEOUT  - default maximum number of WAIT cycles before abort
//   DEF_ERR_DATA - default read data returned on bus error / timeout
//   cnt_width()  - width of the timeout counter for a given TIMEOUT
package mem_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int          DEF_TIMEOUT  = 255;
    localparam logic [31:0] DEF_ERR_DATA = 32'hDEADBEEF;

    // The counter must be able to hold TIMEOUT itself.
    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_TIMEOUT);

endpackage

// File: rtl/mem_bridge_if.sv
// mem_bridge_if: core-side and bus-side signals of the memory bridge.
//   Cpu_Address/Cpu_WriteEnable/Cpu_DataOut - access from the core
//   Cpu_DataIn/Cpu_Stall                    - load data and freeze to the core
//   Bus_Req/Bus_We/Bus_Addr/Bus_WData       - request onto the memory bus
//   Bus_Ack/Bus_Err/Bus_RData               - completion from the memory bus
// Modports:
//   slave  - the bridge's own view
//   master - the surrounding core + memory bus (or a testbench)
interface mem_bridge_if;

    logic [31:0] Cpu_Address;
    logic        Cpu_WriteEnable;
    logic [31:0] Cpu_DataOut;
    logic [31:0] Cpu_DataIn;
    logic        Cpu_Stall;

    logic        Bus_Req;
    logic        Bus_We;
    logic [31:0] Bus_Addr;
    logic [31:0] Bus_WData;
    logic        Bus_Ack;
    logic        Bus_Err;
    logic [31:0] Bus_RData;

    modport slave (
        input  Cpu_Address, Cpu_WriteEnable, Cpu_DataOut,
        output Cpu_DataIn, Cpu_Stall,
        output Bus_Req, Bus_We, Bus_Addr, Bus_WData,
        input  Bus_Ack, Bus_Err, Bus_RData
    );

    modport master (
        output Cpu_Address, Cpu_WriteEnable, Cpu_DataOut,
        input  Cpu_DataIn, Cpu_Stall,
        input  Bus_Req, Bus_We, Bus_Addr, Bus_WData,
        output Bus_Ack, Bus_Err, Bus_RData
    );

endinterface

// File: rtl/mem_bridge_hitbuf.sv
// mem_bridge_hitbuf: single-entry read buffer of the memory bridge.
//   clk, rst_n              - clock, async active-low reset
//   lk_addr, lk_we          - current core access used for the hit compare
//   hit, hit_data           - read hit and buffered data (combinational)
//   fill_en/addr/data       - replace the entry after a successful bus read
//   wt_en/addr/data         - write-through after a successful bus write
module mem_bridge_hitbuf
    import mem_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] lk_addr,
    input  logic        lk_we,
    output logic        hit,
    output logic [31:0] hit_data,
    input  logic        fill_en,
    input  logic [31:0] fill_addr,
    input  logic [31:0] fill_data,
    input  logic        wt_en,
    input  logic [31:0] wt_addr,
    input  logic [31:0] wt_data
);

    logic        valid_q, valid_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] data_q,  data_d;

    // Writes never hit: they always go to the bus so memory stays coherent.
    assign hit      = valid_q && !lk_we && (lk_addr == addr_q);
    assign hit_data = data_q;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (fill_en) begin
            valid_d = 1'b1;
            addr_d  = fill_addr;
            data_d  = fill_data;
        end else if (wt_en && valid_q && (wt_addr == addr_q)) begin
            data_d  = wt_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/mem_bridge.sv
// mem_bridge: bridges the core's shared memory port onto a req/ack bus.
//   Clock, Reset      - clock, async active-low reset
//   bus (slave)       - core access in, load data / stall out, bus req/ack
//   Err_Flag          - sticky error, cleared only by reset
//   Err_Addr          - address of the first failed access
// Parameters:
//   TIMEOUT  - maximum WAIT cycles before an access is aborted (>= 1)
//   ERR_DATA - read data returned on bus error or timeout
module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int          TIMEOUT  = DEF_TIMEOUT,
    parameter logic [31:0] ERR_DATA = DEF_ERR_DATA
) (
    input  logic         Clock,
    input  logic         Reset,
    mem_bridge_if.slave  bus,
    output logic         Err_Flag,
    output logic [31:0]  Err_Addr
);

    localparam int           CW       = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e        state_q,     state_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic          bus_req_q,   bus_req_d;
    logic          req_we_q,    req_we_d;
    logic [31:0]   req_addr_q,  req_addr_d;
    logic [31:0]   req_wdata_q, req_wdata_d;
    logic [31:0]   rsp_data_q,  rsp_data_d;
    logic          err_flag_q,  err_flag_d;
    logic [31:0]   err_addr_q,  err_addr_d;

    logic          hb_hit;
    logic [31:0]   hb_data;
    logic          fill_en;
    logic          wt_en;

    mem_bridge_hitbuf u_hitbuf (
        .clk       (Clock),
        .rst_n     (Reset),
        .lk_addr   (bus.Cpu_Address),
        .lk_we     (bus.Cpu_WriteEnable),
        .hit       (hb_hit),
        .hit_data  (hb_data),
        .fill_en   (fill_en),
        .fill_addr (req_addr_q),
        .fill_data (bus.Bus_RData),
        .wt_en     (wt_en),
        .wt_addr   (req_addr_q),
        .wt_data   (req_wdata_q)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        rsp_data_d  = rsp_data_q;
        err_flag_d  = err_flag_q;
        err_addr_d  = err_addr_q;
        fill_en     = 1'b0;
        wt_en       = 1'b0;

        case (state_q)
            IDLE: begin
                if (!hb_hit) begin
                    state_d     = WAIT;
                    bus_req_d   = 1'b1;
                    req_we_d    = bus.Cpu_WriteEnable;
                    req_addr_d  = bus.Cpu_Address;
                    req_wdata_d = bus.Cpu_DataOut;
                    cnt_d       = '0;
                end
            end

            WAIT: begin
                if (bus.Bus_Ack && !bus.Bus_Err) begin
                    // Checked before the timeout so a last-cycle ack still wins.
                    state_d   = RESP;
                    bus_req_d = 1'b0;
                    cnt_d     = '0;
                    if (!req_we_q) begin
                        fill_en    = 1'b1;
                        rsp_data_d = bus.Bus_RData;
                    end else begin
                        wt_en      = 1'b1;
                    end
                end else if (bus.Bus_Ack || (cnt_q == CNT_LAST)) begin
                    state_d    = RESP;
                    bus_req_d  = 1'b0;
                    cnt_d      = '0;
                    rsp_data_d = ERR_DATA;
                    if (!err_flag_q) begin
                        err_flag_d = 1'b1;
                        err_addr_d = req_addr_q;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            RESP: begin
                state_d = IDLE;
                cnt_d   = '0;
            end

            default: begin
                state_d   = IDLE;
                bus_req_d = 1'b0;
                cnt_d     = '0;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            rsp_data_q  <= '0;
            err_flag_q  <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            rsp_data_q  <= rsp_data_d;
            err_flag_q  <= err_flag_d;
            err_addr_q  <= err_addr_d;
        end
    end

    // Core-facing outputs: hits are served combinationally in IDLE,
    // everything else waits for the registered response in RESP.
    always_comb begin
        bus.Cpu_DataIn = '0;
        bus.Cpu_Stall  = 1'b1;
        case (state_q)
            IDLE: begin
                bus.Cpu_Stall = !hb_hit;
                if (hb_hit) bus.Cpu_DataIn = hb_data;
            end
            RESP: begin
                bus.Cpu_Stall  = 1'b0;
                bus.Cpu_DataIn = rsp_data_q;
            end
            default: begin
                bus.Cpu_Stall  = 1'b1;
                bus.Cpu_DataIn = '0;
            end
        endcase
        // Hold the core frozen for the whole reset.
        if (!Reset) bus.Cpu_Stall = 1'b1;
    end

    assign bus.Bus_Req   = bus_req_q;
    assign bus.Bus_We    = req_we_q;
    assign bus.Bus_Addr  = req_addr_q;
    assign bus.Bus_WData = req_wdata_q;

    assign Err_Flag = err_flag_q;
    assign Err_Addr = err_addr_q;

endmodule

// File: doc/mem_bridge.md
# mem_bridge

Bridges the processor's single shared memory port (instruction fetch and data) to a variable-latency req/ack memory bus. Sits directly downstream of the processor top and consumes its `Mem_Address` / `Mem_WriteEnable` / `Mem_DataOut`. It returns `Mem_DataIn` and a stall that freezes the core while a bus transaction is outstanding. A one-entry read buffer serves repeated reads with zero stall, and a timeout counter traps a dead bus.

## Interface
Parameters:
- `TIMEOUT`, 255: maximum WAIT cycles before an access is aborted; must be ≥1.
- `ERR_DATA`, 32'hDEADBEEF: read data returned on a bus error or timeout.

Ports:
- `Clock`  in  1  sole clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `Cpu_Address`  in  32  core access address.
- `Cpu_WriteEnable`  in  1  1 = store, 0 = load/fetch.
- `Cpu_DataOut`  in  32  store data from the core.
- `Cpu_DataIn`  out  32  load/fetch data to the core.
- `Cpu_Stall`  out  1  freeze the core's PC and all pipeline registers.
- `Bus_Req`  out  1  transaction request.
- `Bus_We`  out  1  transaction is a write.
- `Bus_Addr`  out  32  transaction address.
- `Bus_WData`  out  32  write data.
- `Bus_Ack`  in  1  transaction complete; `Bus_RData` is valid this cycle.
- `Bus_Err`  in  1  transaction failed; sampled only together with `Bus_Ack`.
- `Bus_RData`  in  32  read data.
- `Err_Flag`  out  1  sticky error indicator; cleared only by reset.
- `Err_Addr`  out  32  address of the first failed access.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - The core presents an access every cycle.
  - Hit condition: `Hit_Valid` && !`Cpu_WriteEnable` && `Cpu_Address == Hit_Addr`.
  - On a hit: `Cpu_DataIn = Hit_Data`, `Cpu_Stall = 0`, remain in IDLE.
  - On a miss (any write, or a read that does not hit): `Cpu_Stall = 1` combinationally; latch address, write-enable and data into the request registers; go to WAIT.
- **WAIT**
  - `Bus_Req = 1`. `Bus_We`, `Bus_Addr` and `Bus_WData` come from the request registers and stay stable.
  - `Cpu_Stall = 1`. The timeout counter increments each cycle.
  - On `Bus_Ack && !Bus_Err`:
    - Read: load `Hit_Addr`/`Hit_Data` from the request address and `Bus_RData`, set `Hit_Valid`, latch the response data.
    - Write: if the write address equals `Hit_Addr`, update `Hit_Data` with the write data (write-through, valid kept).
    - Go to RESP.
  - On `Bus_Ack && Bus_Err`, or the counter reaching TIMEOUT:
    - Response data = ERR_DATA.
    - If `Err_Flag` is 0, set it and capture `Err_Addr`.
    - Leave the hit buffer unchanged; deassert `Bus_Req` next cycle; go to RESP.
- **RESP**
  - `Cpu_Stall = 0`, `Cpu_DataIn` = latched response data. The core completes the access this cycle.
  - Next state is IDLE; the counter clears.
- `Bus_Req` is never asserted outside WAIT, and never two cycles after an ack.
- `Cpu_DataIn` is 0 in WAIT.

## Timing
- **Reset values (asynchronous):**
  - State = IDLE; `Hit_Valid = 0`; counter = 0; request and response registers = 0.
  - `Bus_Req`, `Bus_We`, `Bus_Addr`, `Bus_WData` = 0.
  - `Err_Flag = 0`, `Err_Addr = 0`, `Cpu_DataIn = 0`.
  - `Cpu_Stall` is forced to 1 while `Reset` is low.
- **Hit latency:** 0 stall cycles; data is combinational from the buffer.
- **Miss latency:**
  - Miss presented in cycle 0 (stall).
  - `Bus_Req` first high in cycle 1.
  - Ack in cycle 1+n → RESP in cycle 2+n.
  - Stall cycles = 2+n; minimum 2.
- **Timeout:** counter values 0..TIMEOUT-1 in WAIT; when it equals TIMEOUT-1 with no ack, the next state is RESP. At most TIMEOUT WAIT cycles.
- **Ack and timeout in the same cycle:** the ack wins.
- **Reset mid-WAIT:** `Bus_Req` drops immediately (asynchronously); a late `Bus_Ack` after reset is ignored in IDLE.
- `Bus_Ack` outside WAIT is ignored.

## Structure
- Package `mem_bridge_pkg` holds:
  - State enum (IDLE/WAIT/RESP).
  - Default TIMEOUT and ERR_DATA constants.
  - Counter width derived as `$clog2(TIMEOUT+1)`.
- One natural sub-module: `mem_bridge_hitbuf`, holding the single-entry valid/addr/data buffer, its compare logic, and the write-through update.

## Test plan
- **Cold read:**
  - Read 0x100; bus acks after 3 WAIT cycles with 0x1234 → stall high for 5 cycles, then `Cpu_DataIn = 0x1234` in RESP.
  - Immediate re-read of 0x100 → 0 stall, 0x1234.
- **Write-through:**
  - After the cold read, write 0x100 = 0xAAAA (acked after 1 cycle) → `Bus_We = 1`, `Bus_WData = 0xAAAA`.
  - Next read of 0x100 hits with 0xAAAA and no `Bus_Req`.
- **Buffer replacement:** read 0x100 then 0x200 (0x5555) → the next read of 0x100 misses and re-issues `Bus_Req`.
- **Timeout:** TIMEOUT=4, no ack on read of 0x300 → exactly 4 WAIT cycles, RESP returns 0xDEADBEEF, `Err_Flag = 1`, `Err_Addr = 0x300`.
  - A later error at 0x400 leaves `Err_Addr = 0x300`.
- **Bus error:** `Bus_Ack = 1` with `Bus_Err = 1` on read of 0x500 → ERR_DATA returned, buffer unchanged (a previous hit on 0x100 still hits).
- **Reset in WAIT:** `Reset` low mid-WAIT → `Bus_Req` 0 immediately, `Cpu_Stall = 1` during reset.
  - After release, the first read of the previously buffered address misses.
